alu_control_seq: RTL and testbench

Registered, parametrised successor to the combinational ALU control decoder. It sits between the main control unit and the ALU and decodes {AluOp, Funct} into a widened ALU control code. It adds valid/ready handshaking on both sides and sequences the multi-cycle MULT operation, which occupies the ALU for MUL_CYCLES cycles. It also flags unsupported R-type function codes instead of silently defaulting.

---
 rtl/alu_control_seq.sv | 91 +++++++++
 tb/tb_alu_control_seq.sv | 256 +++++++++++++++++++++++++
 2 files changed

// File: rtl/alu_control_seq.sv
// alu_control_seq: registered AluOp/Funct decoder with valid/ready handshake and multi-cycle MULT sequencing
module alu_control_seq #(
  parameter int FUNCT_W = 6,
  parameter int CTRL_W = 3,
  parameter int MUL_CYCLES = 4
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          InValid,
  output logic                          InReady,
  input  logic [1:0]                    AluOp,
  input  logic [FUNCT_W-1:0]            Funct,
  output logic                          OutValid,
  input  logic                          OutReady,
  output logic [CTRL_W-1:0]             ALUControl,
  output logic                          StepActive,
  output logic [$clog2(MUL_CYCLES)-1:0] StepCount,
  output logic                          IllegalOp
);
  localparam int CW = $clog2(MUL_CYCLES);
  localparam logic [CW-1:0] PRE = CW'(MUL_CYCLES - 2);
  localparam logic [1:0] IDLE = 2'd0, MUL = 2'd1, HOLD = 2'd2;
  logic [1:0] state;
  logic [CW-1:0] cnt;
  logic out_valid, ill_q, take, hi_ok, legal, dec_ill, dec_mul;
  logic [5:0] f;
  logic [2:0] code;
  logic [CTRL_W-1:0] ctrl_q;
  always_comb begin
    f = Funct[5:0];
    hi_ok = (Funct >> 6) == '0;
    legal = hi_ok && (f == 6'b100000 || f == 6'b100010 || f == 6'b101010 ||
                      f == 6'b100100 || f == 6'b100101 || f == 6'b011000);
    code = AluOp == 2'b00 ? 3'b000 :
           AluOp == 2'b01 ? 3'b010 :
           AluOp == 2'b11 ? 3'b001 :
           !legal ? 3'b000 :
           f == 6'b100010 ? 3'b010 :
           f == 6'b101010 ? 3'b011 :
           f == 6'b100100 ? 3'b100 :
           f == 6'b100101 ? 3'b101 :
           f == 6'b011000 ? 3'b110 : 3'b000;
    dec_ill = AluOp == 2'b10 && !legal;
    dec_mul = AluOp == 2'b10 && legal && f == 6'b011000;
  end
  assign InReady = !reset && state == IDLE && (!out_valid || OutReady);
  assign take = InValid && InReady;
  assign OutValid = out_valid;
  assign ALUControl = ctrl_q;
  assign IllegalOp = ill_q;
  assign StepActive = state == MUL;
  assign StepCount = cnt;
  // A MULT whose result is consumed on its final step returns straight to IDLE so it is never delivered twice
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= IDLE;
      cnt <= '0;
      out_valid <= 1'b0;
      ctrl_q <= '0;
      ill_q <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (take) begin
            ctrl_q <= CTRL_W'(code);
            ill_q <= dec_ill;
            out_valid <= !dec_mul;
            state <= dec_mul ? MUL : IDLE;
          end else if (OutReady) out_valid <= 1'b0;
        end
        MUL: begin
          if (out_valid) begin
            cnt <= '0;
            state <= OutReady ? IDLE : HOLD;
            out_valid <= !OutReady;
          end else begin
            cnt <= cnt + 1'b1;
            out_valid <= cnt == PRE;
          end
        end
        HOLD: begin
          if (OutReady) begin
            state <= IDLE;
            out_valid <= 1'b0;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_alu_control_seq.sv
// tb_alu_control_seq: vector table, directed multi-cycle sequences and a randomized scoreboard run
module tb_alu_control_seq;
  logic clk = 0, reset = 1;
  logic in_valid = 0, out_ready = 1, in_ready, out_valid, step_active, illegal;
  logic [1:0] aluop = 0, step_count;
  logic [5:0] funct = 0;
  logic [2:0] ctrl;
  logic b_in_valid = 0, b_out_ready = 1, b_in_ready, b_out_valid, b_step_active, b_illegal;
  logic [1:0] b_aluop = 0;
  logic [7:0] b_funct = 0;
  logic [2:0] b_ctrl;
  logic b_step_count;
  int n_cmp = 0, n_err = 0;

  alu_control_seq dut (
    .clk(clk), .reset(reset), .InValid(in_valid), .InReady(in_ready), .AluOp(aluop), .Funct(funct),
    .OutValid(out_valid), .OutReady(out_ready), .ALUControl(ctrl), .StepActive(step_active),
    .StepCount(step_count), .IllegalOp(illegal));

  alu_control_seq #(.FUNCT_W(8), .CTRL_W(3), .MUL_CYCLES(2)) dut_b (
    .clk(clk), .reset(reset), .InValid(b_in_valid), .InReady(b_in_ready), .AluOp(b_aluop), .Funct(b_funct),
    .OutValid(b_out_valid), .OutReady(b_out_ready), .ALUControl(b_ctrl), .StepActive(b_step_active),
    .StepCount(b_step_count), .IllegalOp(b_illegal));

  always #5 clk = ~clk;

  typedef struct { logic [1:0] op; logic [5:0] fn; logic [2:0] code; logic ill; } vec_t;
  typedef struct { logic [2:0] code; logic ill; logic mul; int acc; } exp_t;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic exp_t ref_dec(input logic [1:0] op, input logic [7:0] fn);
    exp_t e;
    e = '{3'b000, 1'b0, 1'b0, 0};
    if (op == 2'b01) e.code = 3'b010;
    else if (op == 2'b11) e.code = 3'b001;
    else if (op == 2'b10)
      case (fn)
        8'h20: e.code = 3'b000;
        8'h22: e.code = 3'b010;
        8'h2A: e.code = 3'b011;
        8'h24: e.code = 3'b100;
        8'h25: e.code = 3'b101;
        8'h18: begin e.code = 3'b110; e.mul = 1'b1; end
        default: e.ill = 1'b1;
      endcase
    return e;
  endfunction

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    vec_t vt[$];
    exp_t q[$];
    logic [5:0] legal_fn[6];
    int cyc;
    legal_fn = '{6'h20, 6'h22, 6'h2A, 6'h24, 6'h25, 6'h18};
    vt = '{'{2'b00, 6'h00, 3'b000, 1'b0}, '{2'b01, 6'h00, 3'b010, 1'b0}, '{2'b11, 6'h00, 3'b001, 1'b0},
           '{2'b10, 6'h20, 3'b000, 1'b0}, '{2'b10, 6'h22, 3'b010, 1'b0}, '{2'b10, 6'h2A, 3'b011, 1'b0},
           '{2'b10, 6'h24, 3'b100, 1'b0}, '{2'b10, 6'h25, 3'b101, 1'b0}, '{2'b10, 6'h3F, 3'b000, 1'b1},
           '{2'b10, 6'h20, 3'b000, 1'b0}, '{2'b10, 6'h00, 3'b000, 1'b1}, '{2'b11, 6'h3F, 3'b001, 1'b0}};
    #12;
    chk("rst_outvalid", out_valid, 0);
    chk("rst_ctrl", ctrl, 0);
    chk("rst_stepactive", step_active, 0);
    chk("rst_stepcount", step_count, 0);
    chk("rst_illegal", illegal, 0);
    chk("rst_inready", in_ready, 0);
    tick();
    reset = 0;
    #1;
    chk("post_rst_inready", in_ready, 1);
    foreach (vt[i]) begin
      in_valid = 1;
      aluop = vt[i].op;
      funct = vt[i].fn;
      #1;
      chk($sformatf("tab%0d_inready", i), in_ready, 1);
      tick();
      chk($sformatf("tab%0d_outvalid", i), out_valid, 1);
      chk($sformatf("tab%0d_ctrl", i), ctrl, vt[i].code);
      chk($sformatf("tab%0d_illegal", i), illegal, vt[i].ill);
    end
    in_valid = 0;
    tick();
    chk("tab_drain", out_valid, 0);

    // MULT with backpressure, an ADD waits upstream
    out_ready = 0;
    in_valid = 1; aluop = 2'b10; funct = 6'h18;
    tick();
    aluop = 2'b00; funct = 0;
    for (int k = 0; k < 4; k++) begin
      chk($sformatf("mul%0d_active", k), step_active, 1);
      chk($sformatf("mul%0d_count", k), step_count, k);
      chk($sformatf("mul%0d_outvalid", k), out_valid, k == 3);
      chk($sformatf("mul%0d_inready", k), in_ready, 0);
      tick();
    end
    for (int k = 0; k < 2; k++) begin
      chk("hold_active", step_active, 0);
      chk("hold_count", step_count, 0);
      chk("hold_outvalid", out_valid, 1);
      chk("hold_ctrl", ctrl, 3'b110);
      chk("hold_inready", in_ready, 0);
      tick();
    end
    out_ready = 1;
    #1;
    chk("hold_release_inready", in_ready, 0);
    tick();
    chk("mul_drained", out_valid, 0);
    chk("idle_inready", in_ready, 1);
    tick();
    chk("add_after_mul_valid", out_valid, 1);
    chk("add_after_mul_ctrl", ctrl, 3'b000);

    // backpressure on a single-cycle result, then same-cycle drain and accept
    out_ready = 0;
    aluop = 2'b01;
    for (int k = 0; k < 5; k++) begin
      tick();
      chk("bp_outvalid", out_valid, 1);
      chk("bp_ctrl", ctrl, 3'b000);
      chk("bp_inready", in_ready, 0);
    end
    out_ready = 1;
    #1;
    chk("bp_release_inready", in_ready, 1);
    tick();
    in_valid = 0;
    chk("bp_sub_valid", out_valid, 1);
    chk("bp_sub_ctrl", ctrl, 3'b010);
    tick();
    chk("bp_sub_drained", out_valid, 0);

    // reset in the middle of a MULT
    in_valid = 1; aluop = 2'b10; funct = 6'h18;
    tick();
    in_valid = 0;
    tick();
    tick();
    chk("mrst_count_before", step_count, 2);
    reset = 1;
    #1;
    chk("mrst_outvalid", out_valid, 0);
    chk("mrst_ctrl", ctrl, 0);
    chk("mrst_active", step_active, 0);
    chk("mrst_count", step_count, 0);
    chk("mrst_inready", in_ready, 0);
    tick();
    reset = 0;
    for (int k = 0; k < 4; k++) begin
      tick();
      chk("mrst_no_valid", out_valid, 0);
    end
    in_valid = 1; aluop = 2'b00; funct = 0;
    tick();
    in_valid = 0;
    chk("mrst_add_valid", out_valid, 1);
    chk("mrst_add_ctrl", ctrl, 3'b000);
    chk("mrst_add_ill", illegal, 0);
    tick();

    // FUNCT_W=8, MUL_CYCLES=2 instance
    b_in_valid = 1; b_aluop = 2'b10; b_funct = 8'h20;
    tick();
    chk("b_add_ctrl", b_ctrl, 3'b000);
    chk("b_add_ill", b_illegal, 0);
    chk("b_add_valid", b_out_valid, 1);
    b_funct = 8'hA0;
    tick();
    chk("b_hi_ill", b_illegal, 1);
    chk("b_hi_ctrl", b_ctrl, 3'b000);
    b_funct = 8'h18;
    tick();
    b_in_valid = 0;
    chk("b_mul0_active", b_step_active, 1);
    chk("b_mul0_count", b_step_count, 0);
    chk("b_mul0_valid", b_out_valid, 0);
    tick();
    chk("b_mul1_count", b_step_count, 1);
    chk("b_mul1_valid", b_out_valid, 1);
    chk("b_mul1_ctrl", b_ctrl, 3'b110);
    chk("b_mul1_ill", b_illegal, 0);
    tick();
    chk("b_mul_done_valid", b_out_valid, 0);
    chk("b_mul_done_active", b_step_active, 0);
    chk("b_mul_done_inready", b_in_ready, 1);

    // randomized run against a transaction-level scoreboard
    cyc = 0;
    in_valid = 0;
    for (int n = 0; n < 3000; n++) begin
      logic ev, es, ir, fire_in, fire_out;
      int ec, age;
      cyc++;
      ev = 0; es = 0; ec = 0;
      if (q.size() != 0) begin
        age = cyc - q[0].acc;
        ev = age >= (q[0].mul ? 4 : 1);
        es = q[0].mul && age >= 1 && age <= 4;
        ec = es ? age - 1 : 0;
      end
      chk("rnd_outvalid", out_valid, ev);
      chk("rnd_active", step_active, es);
      chk("rnd_count", step_count, ec);
      if (ev) begin
        chk("rnd_ctrl", ctrl, q[0].code);
        chk("rnd_illegal", illegal, q[0].ill);
      end
      if (!in_valid || fire_in_prev(q, cyc)) begin
        in_valid = ($urandom % 4) != 0;
        aluop = 2'($urandom);
        funct = ($urandom % 5 != 0) ? legal_fn[$urandom % 6] : 6'($urandom);
      end
      out_ready = ($urandom % 3) != 0;
      #1;
      ir = q.size() == 0 || (!q[0].mul && out_ready);
      chk("rnd_inready", in_ready, ir);
      fire_out = ev && out_ready;
      fire_in = in_valid && ir;
      if (fire_out) void'(q.pop_front());
      if (fire_in) begin
        exp_t e;
        e = ref_dec(aluop, {2'b00, funct});
        e.acc = cyc;
        q.push_back(e);
      end
      @(posedge clk);
      #1;
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  // the held op was taken on the previous edge if the newest queued entry was accepted then
  function automatic logic fire_in_prev(input exp_t q[$], input int cyc);
    return q.size() != 0 && q[q.size()-1].acc == cyc - 1;
  endfunction
endmodule
